// File: rtl/load_store_unit_pkg.sv
// Shared types, widths and lane helpers for the load/store unit.
package load_store_unit_pkg;

  localparam int unsigned WIDTH          = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned LANES          = 4;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } lsu_state_t;

  // Memory-stage output bundle handed to writeback.
  typedef struct packed {
    logic                      valid;
    logic                      load;
    logic [WIDTH-1:0]          read_data;
    logic                      alu_mode;
    logic [WIDTH-1:0]          alu_result;
    logic                      rd;
    logic [REG_ADDR_WIDTH-1:0] rd_address;
    logic                      misaligned;
  } me_bundle_t;

  // Little-endian byte enables for an access of the given size at lane offset off.
  function automatic logic [LANES-1:0] lane_be(mem_size_t size, logic [1:0] off);
    case (size)
      SZ_BYTE: lane_be = 4'b0001 << off;
      SZ_HALF: lane_be = 4'b0011 << off;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  // Extract the addressed lane(s) from a read word and sign/zero extend.
  function automatic logic [WIDTH-1:0] extend(logic [WIDTH-1:0] word, mem_size_t size,
                                              logic [1:0] off, logic uns);
    logic [WIDTH-1:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      SZ_BYTE: extend = uns ? {{(WIDTH-8){1'b0}}, sh[7:0]}
                            : {{(WIDTH-8){sh[7]}}, sh[7:0]};
      SZ_HALF: extend = uns ? {{(WIDTH-16){1'b0}}, sh[15:0]}
                            : {{(WIDTH-16){sh[15]}}, sh[15:0]};
      default: extend = word;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: alignment check, byte enables, store replication, load extraction.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]       st_size,
  input  logic [1:0]       st_off,
  input  logic [WIDTH-1:0] st_data,
  output logic             misaligned_c,
  output logic [LANES-1:0] be_c,
  output logic [WIDTH-1:0] wdata_c,
  input  logic [1:0]       ld_size,
  input  logic [1:0]       ld_off,
  input  logic             ld_unsigned,
  input  logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] ld_data_c
);

  mem_size_t st_size_e;
  mem_size_t ld_size_e;

  assign st_size_e = mem_size_t'(st_size);
  assign ld_size_e = mem_size_t'(ld_size);

  // Alignment check and store-data lane replication.
  always_comb begin
    misaligned_c = 1'b0;
    wdata_c      = st_data;
    case (st_size_e)
      SZ_BYTE: wdata_c = {LANES{st_data[7:0]}};
      SZ_HALF: begin
        misaligned_c = st_off[0];
        wdata_c      = {2{st_data[15:0]}};
      end
      default: misaligned_c = (st_off != 2'b00);
    endcase
  end

  assign be_c      = lane_be(st_size_e, st_off);
  assign ld_data_c = extend(rdata, ld_size_e, ld_off, ld_unsigned);

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store engine: req/ack data-RAM access FSM plus registered writeback bundle.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = WIDTH
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      stall,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                req_op,
  input  logic [1:0]                req_size,
  input  logic                      req_unsigned,
  input  logic [ADDR_WIDTH-1:0]     req_address,
  input  logic [WIDTH-1:0]          req_store_data,
  input  logic                      req_alu_mode,
  input  logic [WIDTH-1:0]          req_alu_result,
  input  logic                      req_rd,
  input  logic [REG_ADDR_WIDTH-1:0] req_rd_address,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-3:0]     mem_addr,
  output logic [LANES-1:0]          mem_be,
  output logic [WIDTH-1:0]          mem_wdata,
  input  logic                      mem_ack,
  input  logic [WIDTH-1:0]          mem_rdata,
  output logic                      valid_me,
  output logic                      load_me,
  output logic                      alu_mode_me,
  output logic                      rd_me,
  output logic [WIDTH-1:0]          read_data_me,
  output logic [WIDTH-1:0]          alu_result_me,
  output logic [REG_ADDR_WIDTH-1:0] rd_address_me,
  output logic                      misaligned_me
);

  lsu_state_t state_q, state_d;
  me_bundle_t me_q, me_d;
  mem_op_t    req_op_e;

  logic                      accept, is_mem, start_access;
  logic                      misaligned_c;
  logic [LANES-1:0]          be_c;
  logic [WIDTH-1:0]          wdata_c, ld_data_c;

  logic                      cap_load, cap_unsigned, cap_alu_mode, cap_rd;
  logic [1:0]                cap_size, cap_off;
  logic [WIDTH-1:0]          cap_alu_result, lat_data;
  logic [REG_ADDR_WIDTH-1:0] cap_rd_address;

  assign req_op_e     = mem_op_t'(req_op);
  assign req_ready    = (state_q == IDLE) && !stall;
  assign accept       = req_valid && req_ready;
  assign is_mem       = (req_op_e == MEM_LOAD) || (req_op_e == MEM_STORE);
  assign start_access = accept && is_mem && !misaligned_c;

  lsu_align u_align (
    .st_size      (req_size),
    .st_off       (req_address[1:0]),
    .st_data      (req_store_data),
    .misaligned_c (misaligned_c),
    .be_c         (be_c),
    .wdata_c      (wdata_c),
    .ld_size      (cap_size),
    .ld_off       (cap_off),
    .ld_unsigned  (cap_unsigned),
    .rdata        (mem_rdata),
    .ld_data_c    (ld_data_c)
  );

  // Next state and next output bundle; the bundle defaults to a bubble.
  always_comb begin
    state_d = state_q;
    me_d    = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (start_access) begin
            state_d = ACCESS;
          end else begin
            me_d.valid      = 1'b1;
            me_d.alu_mode   = is_mem ? 1'b0 : req_alu_mode;
            me_d.alu_result = req_alu_result;
            me_d.rd         = is_mem ? 1'b0 : req_rd;
            me_d.rd_address = req_rd_address;
            me_d.misaligned = is_mem;
          end
        end
      end
      ACCESS, DONE: begin
        if ((state_q == ACCESS && mem_ack) || (state_q == DONE && !stall)) begin
          state_d         = stall ? DONE : IDLE;
          me_d.valid      = 1'b1;
          me_d.load       = cap_load;
          me_d.read_data  = (state_q == DONE) ? lat_data : ld_data_c;
          me_d.alu_mode   = cap_alu_mode;
          me_d.alu_result = cap_alu_result;
          me_d.rd         = cap_load && cap_rd;
          me_d.rd_address = cap_rd_address;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Output bundle register, frozen while stalled.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)       me_q <= '0;
    else if (!stall) me_q <= me_d;
  end

  // RAM port and captured request; port fields hold from acceptance until ack.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_be         <= '0;
      mem_wdata      <= '0;
      cap_load       <= 1'b0;
      cap_unsigned   <= 1'b0;
      cap_size       <= 2'b00;
      cap_off        <= 2'b00;
      cap_alu_mode   <= 1'b0;
      cap_alu_result <= '0;
      cap_rd         <= 1'b0;
      cap_rd_address <= '0;
      lat_data       <= '0;
    end else begin
      if (start_access) begin
        mem_req        <= 1'b1;
        mem_we         <= (req_op_e == MEM_STORE);
        mem_addr       <= req_address[ADDR_WIDTH-1:2];
        mem_be         <= be_c;
        mem_wdata      <= wdata_c;
        cap_load       <= (req_op_e == MEM_LOAD);
        cap_unsigned   <= req_unsigned;
        cap_size       <= req_size;
        cap_off        <= req_address[1:0];
        cap_alu_mode   <= req_alu_mode;
        cap_alu_result <= req_alu_result;
        cap_rd         <= req_rd;
        cap_rd_address <= req_rd_address;
      end else if (state_q == ACCESS && mem_ack) begin
        mem_req  <= 1'b0;
        lat_data <= ld_data_c;
      end
    end
  end

  assign valid_me      = me_q.valid;
  assign load_me       = me_q.load;
  assign read_data_me  = me_q.read_data;
  assign alu_mode_me   = me_q.alu_mode;
  assign alu_result_me = me_q.alu_result;
  assign rd_me         = me_q.rd;
  assign rd_address_me = me_q.rd_address;
  assign misaligned_me = me_q.misaligned;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected retirements queued at drive time, checked on retire.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int unsigned AW = 32;

  logic        clk, nrst, stall;
  logic        req_valid, req_ready;
  logic [1:0]  req_op, req_size;
  logic        req_unsigned;
  logic [AW-1:0] req_address;
  logic [31:0] req_store_data, req_alu_result;
  logic        req_alu_mode, req_rd;
  logic [4:0]  req_rd_address;
  logic        mem_req, mem_we, mem_ack;
  logic [AW-3:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic        valid_me, load_me, alu_mode_me, rd_me, misaligned_me;
  logic [31:0] read_data_me, alu_result_me;
  logic [4:0]  rd_address_me;

  typedef struct {
    logic        load;
    logic [31:0] read_data;
    logic        alu_mode;
    logic [31:0] alu_result;
    logic        rd;
    logic [4:0]  rd_address;
    logic        misaligned;
    logic        chk_alu;
    logic        chk_data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic upd;

  load_store_unit #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .nrst(nrst), .stall(stall),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_address(req_address), .req_store_data(req_store_data),
    .req_alu_mode(req_alu_mode), .req_alu_result(req_alu_result), .req_rd(req_rd),
    .req_rd_address(req_rd_address),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .valid_me(valid_me), .load_me(load_me), .alu_mode_me(alu_mode_me), .rd_me(rd_me),
    .read_data_me(read_data_me), .alu_result_me(alu_result_me),
    .rd_address_me(rd_address_me), .misaligned_me(misaligned_me)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Marks edges at which the bundle register was allowed to update.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) upd <= 1'b0;
    else       upd <= !stall;
  end

  // Retirement monitor: pop the oldest expectation on every fresh valid bundle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (nrst && upd && valid_me) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_retire: got valid_me=1 alu_result_me=%h rd_address_me=%0d, expected no retirement",
                 alu_result_me, rd_address_me);
      end else begin
        e = sb.pop_front();
        if (load_me !== e.load || rd_me !== e.rd || rd_address_me !== e.rd_address ||
            misaligned_me !== e.misaligned ||
            (e.chk_alu && (alu_mode_me !== e.alu_mode || alu_result_me !== e.alu_result)) ||
            (e.chk_data && read_data_me !== e.read_data)) begin
          errors++;
          $display("FAIL retire: got load=%b rd=%b rda=%0d mis=%b am=%b ar=%h data=%h, expected load=%b rd=%b rda=%0d mis=%b am=%b ar=%h data=%h",
                   load_me, rd_me, rd_address_me, misaligned_me, alu_mode_me, alu_result_me, read_data_me,
                   e.load, e.rd, e.rd_address, e.misaligned, e.alu_mode, e.alu_result, e.read_data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d retirements outstanding, expected 0", name, sb.size());
      sb.delete();
    end
    step();
  endtask

  task automatic drive(input logic [1:0] op, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] sdata, input logic am,
                       input logic [31:0] ar, input logic rd, input logic [4:0] rda);
    req_valid      = 1'b1;
    req_op         = op;
    req_size       = size;
    req_unsigned   = uns;
    req_address    = addr;
    req_store_data = sdata;
    req_alu_mode   = am;
    req_alu_result = ar;
    req_rd         = rd;
    req_rd_address = rda;
  endtask

  // One aligned memory access with a RAM model answering after ack_delay cycles.
  task automatic run_mem(input string name, input logic [1:0] op, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic rd, input logic [4:0] rda, input logic [31:0] rdata,
                         input int ack_delay, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_data);
    exp_t e;
    int   n;
    logic is_store;
    is_store     = (op == MEM_STORE);
    e            = '{default: '0};
    e.load       = !is_store;
    e.rd         = !is_store && rd;
    e.rd_address = rda;
    e.read_data  = exp_data;
    e.chk_data   = !is_store;
    drive(op, size, uns, addr, sdata, 1'b0, addr, rd, rda);
    sb.push_back(e);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready: got req_ready=%b, expected 1", name, req_ready);
    end
    step();
    req_valid = 1'b0;
    n = 0;
    while (mem_req !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL %s_req_timeout: got mem_req=%b, expected 1", name, mem_req);
      sb.delete();
      return;
    end
    checks++;
    if (mem_we !== is_store || mem_addr !== 30'(addr >> 2) || mem_be !== exp_be) begin
      errors++;
      $display("FAIL %s_port: got we=%b addr=%h be=%b, expected we=%b addr=%h be=%b",
               name, mem_we, mem_addr, mem_be, is_store, 30'(addr >> 2), exp_be);
    end
    if (is_store) begin
      checks++;
      if (mem_wdata !== exp_wdata) begin
        errors++;
        $display("FAIL %s_wdata: got %h, expected %h", name, mem_wdata, exp_wdata);
      end
    end
    for (int i = 0; i < ack_delay; i++) begin
      step();
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 30'(addr >> 2) || mem_be !== exp_be) begin
        errors++;
        $display("FAIL %s_hold: got req=%b addr=%h be=%b, expected req=1 addr=%h be=%b",
                 name, mem_req, mem_addr, mem_be, 30'(addr >> 2), exp_be);
      end
    end
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    step();
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL %s_req_drop: got mem_req=%b, expected 0", name, mem_req);
    end
    drain(name);
  endtask

  task automatic test_reset();
    nrst = 1'b0; stall = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_size = 2'd0;
    req_unsigned = 1'b0; req_address = '0; req_store_data = '0; req_alu_mode = 1'b0;
    req_alu_result = '0; req_rd = 1'b0; req_rd_address = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) step();
    checks++;
    if (mem_req !== 1'b0 || valid_me !== 1'b0 || rd_me !== 1'b0 || load_me !== 1'b0 ||
        misaligned_me !== 1'b0 || alu_result_me !== 32'h0 || mem_be !== 4'h0) begin
      errors++;
      $display("FAIL reset_state: got req=%b valid=%b rd=%b load=%b mis=%b ar=%h be=%b, expected all 0",
               mem_req, valid_me, rd_me, load_me, misaligned_me, alu_result_me, mem_be);
    end
    nrst = 1'b1;
    step();
  endtask

  task automatic test_passthrough();
    exp_t e;
    e = '{default: '0};
    e.alu_mode = 1'b1; e.alu_result = 32'h0000_1234; e.rd = 1'b1; e.rd_address = 5'd5; e.chk_alu = 1'b1;
    drive(MEM_NONE, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_1234, 1'b1, 5'd5);
    sb.push_back(e);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL passthrough_ready: got req_ready=%b, expected 1", req_ready);
    end
    step();
    req_valid = 1'b0;
    drain("passthrough");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e = '{default: '0};
      e.alu_mode = i[0]; e.alu_result = 32'h1000 + 32'(i) * 32'h111;
      e.rd = !i[0]; e.rd_address = 5'(i + 10); e.chk_alu = 1'b1;
      drive(MEM_NONE, SZ_WORD, 1'b0, 32'h3, 32'h0, e.alu_mode, e.alu_result, e.rd, e.rd_address);
      sb.push_back(e);
      step();
    end
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL back_to_back_throughput: got %0d pending, expected 0", sb.size());
    end
    drain("back_to_back");
  endtask

  task automatic test_byte_load();
    run_mem("lb",  MEM_LOAD, SZ_BYTE, 1'b0, 32'h102, 32'h0, 1'b1, 5'd3, 32'h80FF_7F01, 0,
            4'b0100, 32'h0, 32'hFFFF_FFFF);
    run_mem("lbu", MEM_LOAD, SZ_BYTE, 1'b1, 32'h102, 32'h0, 1'b1, 5'd4, 32'h80FF_7F01, 3,
            4'b0100, 32'h0, 32'h0000_00FF);
  endtask

  task automatic test_store();
    run_mem("sh", MEM_STORE, SZ_HALF, 1'b0, 32'h206, 32'h0000_BEEF, 1'b1, 5'd8, 32'h0, 1,
            4'b1100, 32'hBEEF_BEEF, 32'h0);
    run_mem("sb", MEM_STORE, SZ_BYTE, 1'b0, 32'h301, 32'h1234_56A5, 1'b0, 5'd2, 32'h0, 0,
            4'b0010, 32'hA5A5_A5A5, 32'h0);
  endtask

  task automatic test_misaligned();
    exp_t e;
    e = '{default: '0};
    e.misaligned = 1'b1; e.rd_address = 5'd9;
    drive(MEM_LOAD, SZ_WORD, 1'b0, 32'h101, 32'h0, 1'b0, 32'h101, 1'b1, 5'd9);
    sb.push_back(e);
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem_req !== 1'b0) begin
        errors++;
        $display("FAIL misaligned_no_req: got mem_req=%b, expected 0", mem_req);
      end
      if (i == 0) begin
        checks++;
        if (valid_me !== 1'b1 || misaligned_me !== 1'b1 || rd_me !== 1'b0) begin
          errors++;
          $display("FAIL misaligned_bundle: got valid=%b mis=%b rd=%b, expected 1 1 0",
                   valid_me, misaligned_me, rd_me);
        end
      end
      step();
    end
    drain("misaligned");
  endtask

  task automatic test_stall_ack();
    exp_t e;
    int   n;
    logic held_valid;
    logic [31:0] held_data;
    e = '{default: '0};
    e.load = 1'b1; e.rd = 1'b1; e.rd_address = 5'd6; e.read_data = 32'h0000_8001; e.chk_data = 1'b1;
    drive(MEM_LOAD, SZ_HALF, 1'b1, 32'h10, 32'h0, 1'b0, 32'h10, 1'b1, 5'd6);
    sb.push_back(e);
    step();
    req_valid = 1'b0;
    n = 0;
    while (mem_req !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL stall_req_timeout: got mem_req=%b, expected 1", mem_req);
    end
    mem_ack    = 1'b1;
    mem_rdata  = 32'h1234_8001;
    stall      = 1'b1;
    held_valid = valid_me;
    held_data  = read_data_me;
    for (int i = 0; i < 3; i++) begin
      step();
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      checks++;
      if (req_ready !== 1'b0 || mem_req !== 1'b0 || valid_me !== held_valid ||
          read_data_me !== held_data) begin
        errors++;
        $display("FAIL stall_hold: got ready=%b req=%b valid=%b data=%h, expected 0 0 %b %h",
                 req_ready, mem_req, valid_me, read_data_me, held_valid, held_data);
      end
    end
    stall = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_done_ready: got req_ready=%b, expected 0", req_ready);
    end
    step();
    checks++;
    if (valid_me !== 1'b1 || read_data_me !== 32'h0000_8001) begin
      errors++;
      $display("FAIL stall_release: got valid=%b data=%h, expected 1 00008001", valid_me, read_data_me);
    end
    drain("stall_ack");
  endtask

  task automatic test_reset_mid_access();
    int n;
    drive(MEM_LOAD, SZ_WORD, 1'b0, 32'h40, 32'h0, 1'b0, 32'h40, 1'b1, 5'd7);
    step();
    req_valid = 1'b0;
    n = 0;
    while (mem_req !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    #2;
    nrst = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || valid_me !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_access: got mem_req=%b valid_me=%b, expected 0 0", mem_req, valid_me);
    end
    repeat (2) step();
    nrst = 1'b1;
    step();
    run_mem("lw_after_reset", MEM_LOAD, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b1, 5'd7, 32'hDEAD_BEEF, 1,
            4'b1111, 32'h0, 32'hDEAD_BEEF);
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_back_to_back();
    test_byte_load();
    test_store();
    test_misaligned();
    test_stall_ack();
    test_reset_mid_access();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d entries, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
